// File: rtl/rv32i_ex_sequencer.sv
// Vector sequencer for the RV32I execute stage: fetches vectors from a synchronous
// ROM, drives registered operands, waits the stage latency and scores each result.
module rv32i_ex_sequencer #(
    parameter int NUM_VEC    = 31,
    parameter int IDX_W      = 5,
    parameter int EX_LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    output logic [IDX_W-1:0] vec_addr_o,
    input  logic [31:0]      vec_iw_i,
    input  logic [31:0]      vec_rs1_i,
    input  logic [31:0]      vec_rs2_i,
    input  logic [31:0]      vec_pc_i,
    input  logic [31:0]      vec_exp_i,
    output logic [31:0]      iw_o,
    output logic [31:0]      rs1_data_o,
    output logic [31:0]      rs2_data_o,
    output logic [31:0]      pc_o,
    input  logic [31:0]      ex_result_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W:0]   pass_cnt_o,
    output logic [IDX_W:0]   fail_cnt_o,
    output logic [IDX_W-1:0] first_fail_o,
    output logic             first_fail_vld_o,
    output logic [31:0]      last_result_o
);

    localparam int CNT_W = (EX_LATENCY > 2) ? $clog2(EX_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (EX_LATENCY > 0) ? CNT_W'(EX_LATENCY - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic [31:0]        iw_q, iw_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        exp_q, exp_d;
    logic [IDX_W:0]     passCnt_q, passCnt_d;
    logic [IDX_W:0]     failCnt_q, failCnt_d;
    logic [IDX_W-1:0]   firstFail_q, firstFail_d;
    logic               firstFailVld_q, firstFailVld_d;
    logic [31:0]        lastResult_q, lastResult_d;

    logic lastVec;
    logic resultMatch;

    assign lastVec     = (idx_q == LAST_IDX);
    assign resultMatch = (ex_result_i == exp_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = S_FETCH;
            S_FETCH:        state_d = S_ISSUE;
            S_ISSUE:        state_d = (EX_LATENCY > 0) ? S_WAIT : S_CHECK;
            S_WAIT:         if (waitCnt_q == '0) state_d = S_CHECK;
            S_CHECK: begin
                if (lastVec) begin
                    state_d = S_DONE;
                end else if (step_mode_i) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE:        if (step_i) state_d = S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_PAUSE: busy_o = 1'b1;
            S_DONE:                                     done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Operands stay frozen from ISSUE through CHECK so a multi-cycle stage sees stable inputs.
    always_comb begin
        idx_d          = idx_q;
        waitCnt_d      = waitCnt_q;
        iw_d           = iw_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        pc_d           = pc_q;
        exp_d          = exp_q;
        passCnt_d      = passCnt_q;
        failCnt_d      = failCnt_q;
        firstFail_d    = firstFail_q;
        firstFailVld_d = firstFailVld_q;
        lastResult_d   = lastResult_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    idx_d          = '0;
                    passCnt_d      = '0;
                    failCnt_d      = '0;
                    firstFail_d    = '0;
                    firstFailVld_d = 1'b0;
                    lastResult_d   = '0;
                end
            end
            S_ISSUE: begin
                iw_d      = vec_iw_i;
                rs1_d     = vec_rs1_i;
                rs2_d     = vec_rs2_i;
                pc_d      = vec_pc_i;
                exp_d     = vec_exp_i;
                waitCnt_d = WAIT_LOAD;
            end
            S_WAIT: begin
                if (waitCnt_q != '0) waitCnt_d = waitCnt_q - CNT_W'(1);
            end
            S_CHECK: begin
                lastResult_d = ex_result_i;
                if (resultMatch) begin
                    passCnt_d = passCnt_q + (IDX_W+1)'(1);
                end else begin
                    failCnt_d = failCnt_q + (IDX_W+1)'(1);
                    if (!firstFailVld_q) begin
                        firstFail_d    = idx_q;
                        firstFailVld_d = 1'b1;
                    end
                end
                if (lastVec) begin
                    iw_d  = '0;
                    rs1_d = '0;
                    rs2_d = '0;
                    pc_d  = '0;
                end else if (!step_mode_i) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_PAUSE: begin
                if (step_i) idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q          <= '0;
            waitCnt_q      <= '0;
            iw_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            pc_q           <= '0;
            exp_q          <= '0;
            passCnt_q      <= '0;
            failCnt_q      <= '0;
            firstFail_q    <= '0;
            firstFailVld_q <= 1'b0;
            lastResult_q   <= '0;
        end else begin
            idx_q          <= idx_d;
            waitCnt_q      <= waitCnt_d;
            iw_q           <= iw_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            pc_q           <= pc_d;
            exp_q          <= exp_d;
            passCnt_q      <= passCnt_d;
            failCnt_q      <= failCnt_d;
            firstFail_q    <= firstFail_d;
            firstFailVld_q <= firstFailVld_d;
            lastResult_q   <= lastResult_d;
        end
    end

    assign vec_addr_o       = idx_q;
    assign iw_o             = iw_q;
    assign rs1_data_o       = rs1_q;
    assign rs2_data_o       = rs2_q;
    assign pc_o             = pc_q;
    assign pass_cnt_o       = passCnt_q;
    assign fail_cnt_o       = failCnt_q;
    assign first_fail_o     = firstFail_q;
    assign first_fail_vld_o = firstFailVld_q;
    assign last_result_o    = lastResult_q;

endmodule

// File: tb/tb_rv32i_ex_sequencer.sv
// Directed bench for rv32i_ex_sequencer: one instance with a 2-cycle ALU model,
// one with a combinational ALU model, both fed from the same 4-entry vector table.
module tb_rv32i_ex_sequencer;

    localparam int IDX_W = 2;

    logic clk;
    logic rst_n;

    logic             startA, stepModeA, stepA;
    logic [IDX_W-1:0] vecAddrA;
    logic [31:0]      romIwA, romRs1A, romRs2A, romPcA, romExpA;
    logic [31:0]      iwA, rs1A, rs2A, pcA, exResultA, lastResultA;
    logic             busyA, doneA, firstFailVldA;
    logic [IDX_W:0]   passCntA, failCntA;
    logic [IDX_W-1:0] firstFailA;
    logic [31:0]      aluStage1A, aluStage2A;

    logic             startB;
    logic [IDX_W-1:0] vecAddrB;
    logic [31:0]      romIwB, romRs1B, romRs2B, romPcB, romExpB;
    logic [31:0]      iwB, rs1B, rs2B, pcB, exResultB, lastResultB;
    logic             busyB, doneB, firstFailVldB;
    logic [IDX_W:0]   passCntB, failCntB;
    logic [IDX_W-1:0] firstFailB;

    logic [3:0] faultMask;
    int         checkCount;
    int         passCount;
    int         n;

    // Clock generation: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv32i_ex_sequencer #(.NUM_VEC(4), .IDX_W(IDX_W), .EX_LATENCY(2)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startA), .step_mode_i(stepModeA), .step_i(stepA),
        .vec_addr_o(vecAddrA), .vec_iw_i(romIwA), .vec_rs1_i(romRs1A), .vec_rs2_i(romRs2A),
        .vec_pc_i(romPcA), .vec_exp_i(romExpA), .iw_o(iwA), .rs1_data_o(rs1A),
        .rs2_data_o(rs2A), .pc_o(pcA), .ex_result_i(exResultA), .busy_o(busyA),
        .done_o(doneA), .pass_cnt_o(passCntA), .fail_cnt_o(failCntA),
        .first_fail_o(firstFailA), .first_fail_vld_o(firstFailVldA), .last_result_o(lastResultA)
    );

    rv32i_ex_sequencer #(.NUM_VEC(4), .IDX_W(IDX_W), .EX_LATENCY(0)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startB), .step_mode_i(1'b0), .step_i(1'b0),
        .vec_addr_o(vecAddrB), .vec_iw_i(romIwB), .vec_rs1_i(romRs1B), .vec_rs2_i(romRs2B),
        .vec_pc_i(romPcB), .vec_exp_i(romExpB), .iw_o(iwB), .rs1_data_o(rs1B),
        .rs2_data_o(rs2B), .pc_o(pcB), .ex_result_i(exResultB), .busy_o(busyB),
        .done_o(doneB), .pass_cnt_o(passCntB), .fail_cnt_o(failCntB),
        .first_fail_o(firstFailB), .first_fail_vld_o(firstFailVldB), .last_result_o(lastResultB)
    );

    // Vector table: ADD, SUB, SLL, OR on x3 <- x1 op x2, PC = 4*index.
    function automatic logic [31:0] vecIw(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    return 32'h002081B3;
            2'd1:    return 32'h402081B3;
            2'd2:    return 32'h002091B3;
            default: return 32'h0020E1B3;
        endcase
    endfunction

    function automatic logic [31:0] vecRs1(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    return 32'h02000000;
            2'd1:    return 32'h00000003;
            2'd2:    return 32'h02000000;
            default: return 32'h00000003;
        endcase
    endfunction

    function automatic logic [31:0] vecRs2(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    return 32'h30000000;
            2'd1:    return 32'h00000002;
            2'd2:    return 32'h00000002;
            default: return 32'h00000002;
        endcase
    endfunction

    function automatic logic [31:0] vecExp(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    return 32'h32000000;
            2'd1:    return 32'h00000001;
            2'd2:    return 32'h08000000;
            default: return 32'h00000003;
        endcase
    endfunction

    // Reference ALU for the four opcodes used; faultMask forces a wrong result per vector.
    function automatic logic [31:0] aluModel(input logic [31:0] iw, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc);
        logic [31:0] r;
        case (iw[14:12])
            3'b000:  r = iw[30] ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b110:  r = a | b;
            default: r = 32'h0;
        endcase
        if (faultMask[pc[3:2]]) r = 32'h0;
        return r;
    endfunction

    always @(posedge clk) begin
        romIwA     <= vecIw(vecAddrA);
        romRs1A    <= vecRs1(vecAddrA);
        romRs2A    <= vecRs2(vecAddrA);
        romPcA     <= {28'h0, vecAddrA, 2'b00};
        romExpA    <= vecExp(vecAddrA);
        romIwB     <= vecIw(vecAddrB);
        romRs1B    <= vecRs1(vecAddrB);
        romRs2B    <= vecRs2(vecAddrB);
        romPcB     <= {28'h0, vecAddrB, 2'b00};
        romExpB    <= vecExp(vecAddrB);
        aluStage1A <= aluModel(iwA, rs1A, rs2A, pcA);
        aluStage2A <= aluStage1A;
    end

    assign exResultA = aluStage2A;
    assign exResultB = aluModel(iwB, rs1B, rs2B, pcB);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sm, input logic st);
        startA    = s;
        stepModeA = sm;
        stepA     = st;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, observed, expected);
    endtask

    // Pulses start now and counts cycles until done; extra start/step pulses at chosen cycles.
    task automatic runPassA(input int startAt1, input int startAt2, input int stepAt,
                            output int cycles);
        applyStimulus(1'b1, 1'b0, 1'b0);
        cycles = 0;
        while (cycles < 200) begin
            tick();
            cycles++;
            if (doneA) break;
            applyStimulus((cycles == startAt1) || (cycles == startAt2), 1'b0, cycles == stepAt);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        faultMask  = 4'b0000;
        rst_n      = 1'b0;
        startB     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_busy", {31'h0, busyA}, 32'h0);
        checkOutput("rst_done", {31'h0, doneA}, 32'h0);
        checkOutput("rst_addr", {30'h0, vecAddrA}, 32'h0);
        checkOutput("rst_iw", iwA, 32'h0);
        checkOutput("rst_pass", {29'h0, passCntA}, 32'h0);
        checkOutput("rst_last", lastResultA, 32'h0);
        checkOutput("rst_vld", {31'h0, firstFailVldA}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_busy", {31'h0, busyA | doneA}, 32'h0);
        end

        $display("[TB] clean pass");
        runPassA(-1, -1, -1, n);
        checkOutput("clean_done_cycles", n, 21);
        checkOutput("clean_pass", {29'h0, passCntA}, 32'd4);
        checkOutput("clean_fail", {29'h0, failCntA}, 32'd0);
        checkOutput("clean_vld", {31'h0, firstFailVldA}, 32'h0);
        checkOutput("clean_last", lastResultA, 32'h00000003);
        checkOutput("clean_busy", {31'h0, busyA}, 32'h0);
        checkOutput("clean_iw_zero", iwA, 32'h0);

        $display("[TB] injected fault");
        faultMask = 4'b0100;
        runPassA(-1, -1, -1, n);
        checkOutput("fault_done_cycles", n, 21);
        checkOutput("fault_pass", {29'h0, passCntA}, 32'd3);
        checkOutput("fault_fail", {29'h0, failCntA}, 32'd1);
        checkOutput("fault_first", {30'h0, firstFailA}, 32'd2);
        checkOutput("fault_vld", {31'h0, firstFailVldA}, 32'h1);
        faultMask = 4'b1100;
        runPassA(-1, -1, -1, n);
        checkOutput("fault2_pass", {29'h0, passCntA}, 32'd2);
        checkOutput("fault2_fail", {29'h0, failCntA}, 32'd2);
        checkOutput("fault2_first", {30'h0, firstFailA}, 32'd2);
        checkOutput("fault2_last", lastResultA, 32'h0);

        $display("[TB] step mode");
        faultMask = 4'b0000;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("step0_pass", {29'h0, passCntA}, 32'd1);
        checkOutput("step0_iw", iwA, 32'h002081B3);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("pause_busy", {31'h0, busyA}, 32'h1);
            checkOutput("pause_addr", {30'h0, vecAddrA}, 32'd0);
        end
        for (int v = 1; v < 4; v++) begin
            if (v == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                repeat (5) tick();
                checkOutput("pause_drop_mode_addr", {30'h0, vecAddrA}, 32'd2);
                checkOutput("pause_drop_mode_busy", {31'h0, busyA}, 32'h1);
            end
            applyStimulus(1'b0, v < 3, 1'b1);
            tick();
            applyStimulus(1'b0, v < 3, 1'b0);
            checkOutput("step_fetch_addr", {30'h0, vecAddrA}, v);
            repeat (5) tick();
            checkOutput("step_pass", {29'h0, passCntA}, v + 1);
            checkOutput("step_done", {31'h0, doneA}, (v == 3) ? 32'h1 : 32'h0);
        end

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("midrun_addr", {30'h0, vecAddrA}, 32'd1);
        checkOutput("midrun_pass", {29'h0, passCntA}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'h0, busyA}, 32'h0);
        checkOutput("async_addr", {30'h0, vecAddrA}, 32'd0);
        checkOutput("async_iw", iwA, 32'h0);
        checkOutput("async_pass", {29'h0, passCntA}, 32'd0);
        checkOutput("async_last", lastResultA, 32'h0);
        tick();
        rst_n = 1'b1;
        runPassA(-1, -1, -1, n);
        checkOutput("rerun_cycles", n, 21);
        checkOutput("rerun_pass", {29'h0, passCntA}, 32'd4);
        checkOutput("rerun_fail", {29'h0, failCntA}, 32'd0);

        $display("[TB] start handling");
        runPassA(7, 15, 10, n);
        checkOutput("ignore_start_cycles", n, 21);
        checkOutput("ignore_start_pass", {29'h0, passCntA}, 32'd4);
        faultMask = 4'b0100;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_clear_pass", {29'h0, passCntA}, 32'd0);
        checkOutput("restart_clear_last", lastResultA, 32'h0);
        checkOutput("restart_busy", {31'h0, busyA}, 32'h1);
        n = 1;
        while (!doneA && n < 200) begin
            tick();
            n++;
        end
        checkOutput("restart_cycles", n, 21);
        checkOutput("restart_fail", {29'h0, failCntA}, 32'd1);

        $display("[TB] zero latency");
        faultMask = 4'b0000;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        n = 1;
        while (!doneB && n < 200) begin
            tick();
            n++;
        end
        checkOutput("l0_done_cycles", n, 13);
        checkOutput("l0_pass", {29'h0, passCntB}, 32'd4);
        checkOutput("l0_fail", {29'h0, failCntB}, 32'd0);
        checkOutput("l0_last", lastResultB, 32'h00000003);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
